tracebuf_trig: RTL and testbench
================================

// Module: tracebuf_trig
// PURPOSE
//  Triggered trace-capture buffer; next generation of the small ring trace buffer (same single-clock domain).
//  - Records data words into a 2**BITDEPTH ring while armed.
//  - Freezes the record a programmable number of entries after a trigger, so the window around the event is kept.
//  - Readout is through the same FIFO-style dequeue port. Sits between bus-snoop logic and the SPI/register readout.
// PARAMETERS
//  BITWIDTH  8   data bits per trace entry
//  BITDEPTH  4   buffer holds 2**BITDEPTH entries
//  OVFWIDTH  8   width of lost-entry counter (saturating)
//  TSWIDTH   8   timestamp width; used only with TRACEBUF_TIMESTAMP_EN
// PORTS
//  clk          in   1           system clock (48MHz)
//  reset        in   1           asynchronous reset, active-high
//  wport_i      in   BITWIDTH    trace data to record
//  wenq_i       in   1           record wport_i this cycle
//  trig_i       in   1           trigger event (single-cycle pulse)
//  arm_i        in   1           empty buffer and start recording
//  clear_i      in   1           empty buffer, go IDLE
//  stopfull_i   in   1           1: drop writes when full; 0: overwrite oldest (ring)
//  posttrig_i   in   BITDEPTH+1  entries to record after the trigger entry; sampled on trigger
//  rport_o      out  ENTRYW      oldest entry; valid when empty_o=0
//  rdeq_i       in   1           dequeue oldest entry; ignored when empty
//  state_o      out  2           0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
//  full_o / empty_o  out 1       buffer full / empty
//  count_o      out  BITDEPTH+1  entries held
//  pretrig_o    out  BITDEPTH+1  held entries older than the trigger entry
//  ovf_o        out  OVFWIDTH    entries lost to overwrite or drop since arm
// BEHAVIOUR
//  - Reset (async) / clear_i (sync, highest priority):
//    - Pointers=0, count_o=0, empty_o=1, full_o=0, pretrig_o=0, ovf_o=0, state_o=IDLE.
//  - arm_i (any state, below clear_i): same emptying; state->ARMED; timestamp counter <=0.
//  - FSM:
//    - IDLE/DONE: wenq_i ignored.
//    - ARMED: wenq_i records; trig_i -> TRIGGERED.
//      - The wenq_i in the trigger cycle (if any) is the trigger entry.
//      - pretrig_o <= count of entries already held, excluding the trigger entry.
//      - postcnt <= posttrig_i.
//      - If posttrig_i=0 and that cycle wrote the trigger entry, go directly to DONE.
//      - If posttrig_i=0 and no write in the trigger cycle, the next write is the trigger entry, then DONE.
//    - TRIGGERED: each recorded write decrements postcnt; the write that makes postcnt 0 -> DONE next cycle.
//    - trig_i outside ARMED: ignored.
//  - Write when full:
//    - stopfull_i=0: overwrite oldest; rptr+1; count stays 2**BITDEPTH; ovf_o+1 (saturating); pretrig_o-1 (floor 0).
//    - stopfull_i=1: entry dropped; ovf_o+1; in TRIGGERED postcnt still decrements (window closes on time).
//  - rdeq_i (any state, non-empty):
//    - rptr+1, count-1, full_o=0, empty_o=(count was 1); pretrig_o-1 (floor 0).
//  - Simultaneous wenq_i & rdeq_i:
//    - Non-empty: rptr+1, write stored, count unchanged, ovf_o unchanged even when full.
//    - Empty: write stored, rdeq ignored.
//  - Latency: write visible on rport_o the next cycle when empty; rport_o = mem[rptr] combinational read.
//  - Pointers wrap modulo 2**BITDEPTH; full_o = (count==2**BITDEPTH); all counters saturate, never wrap.
// CONFIGURATION
//  - TRACEBUF_TIMESTAMP_EN defined:
//    - Free-running TSWIDTH counter, saturating at all-ones, reset on arm.
//    - Each entry is {timestamp, wport_i}; ENTRYW=TSWIDTH+BITWIDTH.
//  - Undefined: no counter; ENTRYW=BITWIDTH.
// STRUCTURE
//  - tracebuf_defs.vh (shared include): state encodings TB_IDLE/TB_ARMED/TB_TRIG/TB_DONE, ENTRYW macro.
//  - Sub-module trace_ram: 1W1R inferred memory, combinational read port; FSM/pointers/counters stay in top.
// TESTING
//  1 Arm, write 0x01..0x05, trig_i with write 0x06, posttrig=2, write 0x07,0x08,0x09
//    -> DONE after 0x08; 0x09 ignored; read 01..08; pretrig_o=5 before reads.
//  2 Depth 16, ring mode, arm, write 20 entries, no trigger
//    -> count=16, ovf_o=4, reads return entries 5..20.
//  3 stopfull_i=1, arm, write 20 entries -> entries 1..16 kept, ovf_o=4, full_o=1.
//  4 Full buffer, wenq_i & rdeq_i same cycle -> count=16, ovf_o unchanged, oldest advanced by 1.
//  5 Assert reset mid-TRIGGERED -> outputs immediately IDLE/empty without a clock edge.
//  6 clear_i & arm_i same cycle -> IDLE; trig_i while IDLE ignored.

Source files
------------

// File: rtl/tracebuf_trig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tracebuf_trig_pkg
// Brief    : Shared state encodings and entry-width helper for the triggered
//            trace buffer. Optional macro: TRACEBUF_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
package tracebuf_trig_pkg;

    localparam logic [1:0] TB_IDLE  = 2'd0;
    localparam logic [1:0] TB_ARMED = 2'd1;
    localparam logic [1:0] TB_TRIG  = 2'd2;
    localparam logic [1:0] TB_DONE  = 2'd3;

`ifdef TRACEBUF_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Stored entry width: the timestamp rides above the data when enabled.
    function automatic int entry_width(input int bw, input int tsw);
        return TS_EN ? (bw + tsw) : bw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tracebuf_trig_if.sv
`default_nettype none
// ============================================================================
// Module   : tracebuf_trig_if
// Brief    : Control, record and dequeue signals of the triggered trace buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface tracebuf_trig_if
    import tracebuf_trig_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int BITDEPTH = 4,
    parameter int OVFWIDTH = 8,
    parameter int TSWIDTH  = 8
);
    localparam int ENTRYW = entry_width(BITWIDTH, TSWIDTH);

    logic [BITWIDTH-1:0] wport_i;
    logic                wenq_i;
    logic                trig_i;
    logic                arm_i;
    logic                clear_i;
    logic                stopfull_i;
    logic [BITDEPTH:0]   posttrig_i;
    logic                rdeq_i;
    logic [ENTRYW-1:0]   rport_o;
    logic [1:0]          state_o;
    logic                full_o;
    logic                empty_o;
    logic [BITDEPTH:0]   count_o;
    logic [BITDEPTH:0]   pretrig_o;
    logic [OVFWIDTH-1:0] ovf_o;

    modport master (
        output wport_i, wenq_i, trig_i, arm_i, clear_i, stopfull_i, posttrig_i, rdeq_i,
        input  rport_o, state_o, full_o, empty_o, count_o, pretrig_o, ovf_o
    );

    modport slave (
        input  wport_i, wenq_i, trig_i, arm_i, clear_i, stopfull_i, posttrig_i, rdeq_i,
        output rport_o, state_o, full_o, empty_o, count_o, pretrig_o, ovf_o
    );

endinterface
`default_nettype wire

// File: rtl/tracebuf_trig_ram.sv
`default_nettype none
// ============================================================================
// Module   : tracebuf_trig_ram
// Brief    : 1W1R inferred memory with a combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
module tracebuf_trig_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [DW-1:0] i_wdata,
    input  wire logic [AW-1:0] i_raddr,
    output logic      [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/tracebuf_trig.sv
`default_nettype none
// ============================================================================
// Module   : tracebuf_trig
// Brief    : Triggered ring trace buffer; freezes a programmable number of
//            entries after a trigger. Optional macro: TRACEBUF_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tracebuf_trig
    import tracebuf_trig_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int BITDEPTH = 4,
    parameter int OVFWIDTH = 8,
    parameter int TSWIDTH  = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    tracebuf_trig_if.slave bus
);

    localparam int              ENTRYW  = entry_width(BITWIDTH, TSWIDTH);
    localparam int              CW      = BITDEPTH + 1;
    localparam logic [CW-1:0]   c_DEPTH = {1'b1, {BITDEPTH{1'b0}}};
    localparam logic [CW-1:0]   c_ONE   = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [BITDEPTH-1:0] r_wptr;
    logic [BITDEPTH-1:0] r_rptr;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       r_pretrig;
    logic [CW-1:0]       r_postcnt;
    logic [CW-1:0]       w_pretrig_base;
    logic [OVFWIDTH-1:0] r_ovf;
    logic                r_need_entry;
    logic                w_recording;
    logic                w_ctl;
    logic                w_full;
    logic                w_deq;
    logic                w_wr;
    logic                w_lost;
    logic                w_overwrite;
    logic                w_store;
    logic                w_trig_ev;
    logic [ENTRYW-1:0]   w_entry;
    logic [ENTRYW-1:0]   w_rdata;

    assign w_ctl          = bus.clear_i | bus.arm_i;
    assign w_full         = (r_count == c_DEPTH);
    assign w_deq          = bus.rdeq_i & (r_count != '0) & ~w_ctl;
    assign w_wr           = bus.wenq_i & w_recording & ~w_ctl;
    // A write into a full buffer loses an entry unless a dequeue frees the slot.
    assign w_lost         = w_wr & w_full & ~w_deq;
    assign w_overwrite    = w_lost & ~bus.stopfull_i;
    assign w_store        = w_wr & ~(w_lost & bus.stopfull_i);
    assign w_trig_ev      = (r_state == TB_ARMED) & bus.trig_i & ~w_ctl;
    assign w_pretrig_base = w_trig_ev ? r_count : r_pretrig;

`ifdef TRACEBUF_TIMESTAMP_EN
    logic [TSWIDTH-1:0] r_ts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts <= '0;
        end else if (bus.arm_i & ~bus.clear_i) begin
            r_ts <= '0;
        end else if (r_ts != '1) begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_entry = {r_ts, bus.wport_i};
`else
    assign w_entry = bus.wport_i;
`endif

    tracebuf_trig_ram #(
        .AW (BITDEPTH),
        .DW (ENTRYW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_store),
        .i_waddr (r_wptr),
        .i_wdata (w_entry),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= TB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Without a write in the trigger cycle, the next write is the trigger entry
    // and does not consume the post-trigger budget.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear_i) begin
            w_state_nxt = TB_IDLE;
        end else if (bus.arm_i) begin
            w_state_nxt = TB_ARMED;
        end else begin
            case (r_state)
                TB_ARMED: begin
                    if (bus.trig_i) begin
                        w_state_nxt = ((bus.posttrig_i == '0) && bus.wenq_i) ? TB_DONE : TB_TRIG;
                    end
                end
                TB_TRIG: begin
                    if (w_wr && (r_need_entry ? (r_postcnt == '0) : (r_postcnt <= c_ONE))) begin
                        w_state_nxt = TB_DONE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_comb begin
        w_recording   = (r_state == TB_ARMED) || (r_state == TB_TRIG);
        bus.state_o   = r_state;
        bus.full_o    = w_full;
        bus.empty_o   = (r_count == '0);
        bus.count_o   = r_count;
        bus.pretrig_o = r_pretrig;
        bus.ovf_o     = r_ovf;
        bus.rport_o   = w_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_pretrig    <= '0;
            r_postcnt    <= '0;
            r_ovf        <= '0;
            r_need_entry <= 1'b0;
        end else if (w_ctl) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_pretrig    <= '0;
            r_postcnt    <= '0;
            r_ovf        <= '0;
            r_need_entry <= 1'b0;
        end else begin
            if (w_store) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_deq || w_overwrite) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_store && !w_deq && !w_full) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq && !w_wr) begin
                r_count <= r_count - 1'b1;
            end
            if (w_lost && (r_ovf != '1)) begin
                r_ovf <= r_ovf + 1'b1;
            end
            // Losing the oldest entry shrinks the pre-trigger history, floor 0.
            if ((w_deq || w_overwrite) && (w_pretrig_base != '0)) begin
                r_pretrig <= w_pretrig_base - 1'b1;
            end else begin
                r_pretrig <= w_pretrig_base;
            end
            if (w_trig_ev) begin
                r_postcnt    <= bus.posttrig_i;
                r_need_entry <= ~bus.wenq_i;
            end else if ((r_state == TB_TRIG) && w_wr) begin
                if (r_need_entry) begin
                    r_need_entry <= 1'b0;
                end else if (r_postcnt != '0) begin
                    r_postcnt <= r_postcnt - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tracebuf_trig.sv
`default_nettype none
// ============================================================================
// Module   : tb_tracebuf_trig
// Brief    : Scoreboard bench for tracebuf_trig: directed stimulus queues the
//            expected readout, a monitor checks every dequeued entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tracebuf_trig;

    localparam int BW = 8;
    localparam int BD = 4;
    localparam int OW = 8;
    localparam int TW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [BW-1:0] exp_q [$];

    tracebuf_trig_if #(.BITWIDTH(BW), .BITDEPTH(BD), .OVFWIDTH(OW), .TSWIDTH(TW)) bif ();

    tracebuf_trig #(.BITWIDTH(BW), .BITDEPTH(BD), .OVFWIDTH(OW), .TSWIDTH(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // Read monitor: every accepted dequeue must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && bif.rdeq_i) begin
            if (!bif.empty_o) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rdata: unexpected entry got %0h, required none", bif.rport_o[BW-1:0]);
                end else begin
                    logic [BW-1:0] w_exp;
                    w_exp = exp_q.pop_front();
                    if (bif.rport_o[BW-1:0] !== w_exp) begin
                        n_bad++;
                        $display("FAIL rdata: got %0h required %0h", bif.rport_o[BW-1:0], w_exp);
                    end
                end
            end else if (exp_q.size() != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rdata: buffer empty, required %0h", exp_q[0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d);
        bif.wenq_i  = 1'b1;
        bif.wport_i = BW'(d);
        tick();
        bif.wenq_i  = 1'b0;
    endtask

    task automatic do_arm();
        bif.arm_i = 1'b1;
        tick();
        bif.arm_i = 1'b0;
    endtask

    task automatic rd(input int n);
        for (int i = 0; i < n; i++) begin
            bif.rdeq_i = 1'b1;
            tick();
            bif.rdeq_i = 1'b0;
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) begin
            exp_q.push_back(BW'(v));
        end
    endtask

    task automatic chk_status(input string tag, input int st, input int cnt, input int ovf, input int pre);
        chk({tag, " state"},   int'(bif.state_o),   st);
        chk({tag, " count"},   int'(bif.count_o),   cnt);
        chk({tag, " ovf"},     int'(bif.ovf_o),     ovf);
        chk({tag, " pretrig"}, int'(bif.pretrig_o), pre);
        chk({tag, " full"},    int'(bif.full_o),    (cnt == 16) ? 1 : 0);
        chk({tag, " empty"},   int'(bif.empty_o),   (cnt == 0) ? 1 : 0);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bif.wport_i    = '0;
        bif.wenq_i     = 1'b0;
        bif.trig_i     = 1'b0;
        bif.arm_i      = 1'b0;
        bif.clear_i    = 1'b0;
        bif.stopfull_i = 1'b0;
        bif.posttrig_i = '0;
        bif.rdeq_i     = 1'b0;
        #1 reset = 1'b1;
        #3;
        chk_status("reset", 0, 0, 0, 0);
        #3 reset = 1'b0;
        tick();

        // Trigger with a write, two post-trigger entries, then frozen.
        do_arm();
        chk("t1 armed", int'(bif.state_o), 1);
        for (int v = 1; v <= 5; v++) wr(v);
        bif.trig_i     = 1'b1;
        bif.posttrig_i = 5'd2;
        wr(6);
        bif.trig_i     = 1'b0;
        chk_status("t1 trig", 2, 6, 0, 5);
        wr(7);
        chk("t1 after 7 state", int'(bif.state_o), 2);
        wr(8);
        wr(9);
        chk_status("t1 done", 3, 8, 0, 5);
        push_range(1, 8);
        rd(8);
        chk_status("t1 drained", 3, 0, 0, 0);

        // Ring mode overwrite without a trigger.
        bif.stopfull_i = 1'b0;
        do_arm();
        for (int v = 1; v <= 20; v++) wr(v);
        chk_status("t2 ring", 1, 16, 4, 0);
        push_range(5, 20);
        rd(16);
        chk("t2 drained", int'(bif.empty_o), 1);

        // Stop-when-full drops, then simultaneous write and dequeue on full.
        bif.stopfull_i = 1'b1;
        do_arm();
        for (int v = 1; v <= 20; v++) wr(v);
        chk_status("t3 stopfull", 1, 16, 4, 0);
        exp_q.push_back(8'h01);
        bif.rdeq_i = 1'b1;
        wr(8'h21);
        bif.rdeq_i = 1'b0;
        chk_status("t4 wr+rd", 1, 16, 4, 0);
        push_range(2, 16);
        exp_q.push_back(8'h21);
        rd(16);
        bif.stopfull_i = 1'b0;

        // posttrig=0 with no write in the trigger cycle: next write closes.
        do_arm();
        wr(8'h10);
        bif.trig_i     = 1'b1;
        bif.posttrig_i = '0;
        tick();
        bif.trig_i     = 1'b0;
        chk("pt0 state trig", int'(bif.state_o), 2);
        wr(8'h11);
        wr(8'h12);
        chk_status("pt0 done", 3, 2, 0, 1);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        rd(2);

        // Asynchronous reset while TRIGGERED.
        do_arm();
        wr(1);
        bif.trig_i     = 1'b1;
        bif.posttrig_i = 5'd3;
        wr(2);
        bif.trig_i     = 1'b0;
        chk("t5 trig", int'(bif.state_o), 2);
        #2 reset = 1'b1;
        #1;
        chk_status("t5 async reset", 0, 0, 0, 0);
        #1 reset = 1'b0;
        tick();

        // clear beats arm; trigger and writes ignored in IDLE.
        do_arm();
        wr(8'h33);
        wr(8'h34);
        bif.clear_i = 1'b1;
        bif.arm_i   = 1'b1;
        tick();
        bif.clear_i = 1'b0;
        bif.arm_i   = 1'b0;
        chk_status("t6 clear", 0, 0, 0, 0);
        bif.trig_i = 1'b1;
        tick();
        bif.trig_i = 1'b0;
        wr(8'h35);
        chk_status("t6 idle", 0, 0, 0, 0);
        rd(1);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
